// File: rtl/ram16x4_master.sv
// ram16x4_master: clocked initiator for one SN74189 16x4 RAM.
// Host side is a single-transaction req/busy/done handshake plus a bulk-clear
// command. RAM side sequences address/data setup, the active-low strobes and
// hold. The chip returns complemented data, so read data is inverted on capture.
module ram16x4_master #(
    parameter int unsigned WR_PULSE = 1,
    parameter int unsigned RD_WAIT  = 1
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       req,
    input  logic       we,
    input  logic [3:0] addr,
    input  logic [3:0] wdata,
    input  logic       clr_req,
    output logic       busy,
    output logic       done,
    output logic [3:0] rdata,
    output logic [3:0] ram_a,
    output logic [3:0] ram_di,
    input  logic [3:0] ram_do,
    output logic       ram_s_bar,
    output logic       ram_w_bar
);

    typedef enum logic [2:0] {
        StIdle,
        StWSetup,
        StWPulse,
        StWHold,
        StRSetup,
        StRSample
    } state_e;

    // Cycle counters are loaded with length-1 and count down to zero.
    localparam logic [3:0] WrLoad = 4'(WR_PULSE - 1);
    localparam logic [3:0] RdLoad = 4'(RD_WAIT - 1);

    state_e     state_q, state_d;
    logic [3:0] wait_q;
    logic [3:0] clr_cnt_q;
    logic       clearing_q;
    logic       busy_d, done_d, s_bar_d, w_bar_d;
    logic       start_clr, start_req;

    // clr_req wins over req; neither is looked at outside IDLE.
    assign start_clr = (state_q == StIdle) && clr_req;
    assign start_req = (state_q == StIdle) && !clr_req && req;

    // State register
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_clr) begin
                    state_d = StWSetup;
                end else if (start_req) begin
                    state_d = we ? StWSetup : StRSetup;
                end
            end
            StWSetup:  state_d = StWPulse;
            StWPulse:  if (wait_q == 4'd0) state_d = StWHold;
            StWHold: begin
                // During a clear, chain straight into the next address.
                if (clearing_q && (clr_cnt_q != 4'd15)) begin
                    state_d = StWSetup;
                end else begin
                    state_d = StIdle;
                end
            end
            StRSetup:  if (wait_q == 4'd0) state_d = StRSample;
            StRSample: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Output next-values, decoded from the upcoming state so outputs are registered
    always_comb begin
        busy_d  = (state_d != StIdle);
        s_bar_d = !((state_d == StWPulse) || (state_d == StRSetup));
        w_bar_d = (state_d != StWPulse);
        done_d  = (state_q == StRSample) || ((state_q == StWHold) && (state_d == StIdle));
    end

    // Registered handshake/strobe outputs and the phase-length counter
    always_ff @(posedge CLK) begin
        if (CLR) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            ram_s_bar <= 1'b1;
            ram_w_bar <= 1'b1;
            wait_q    <= 4'd0;
        end else begin
            busy      <= busy_d;
            done      <= done_d;
            ram_s_bar <= s_bar_d;
            ram_w_bar <= w_bar_d;
            if (state_q == StWSetup) begin
                wait_q <= WrLoad;
            end else if (state_q == StIdle) begin
                wait_q <= RdLoad;
            end else if (wait_q != 4'd0) begin
                wait_q <= wait_q - 4'd1;
            end
        end
    end

    // Datapath: address/data latching, clear sequencing and read capture
    always_ff @(posedge CLK) begin
        if (CLR) begin
            ram_a      <= 4'd0;
            ram_di     <= 4'd0;
            rdata      <= 4'd0;
            clr_cnt_q  <= 4'd0;
            clearing_q <= 1'b0;
        end else begin
            if (start_clr) begin
                clearing_q <= 1'b1;
                clr_cnt_q  <= 4'd0;
                ram_a      <= 4'd0;
                ram_di     <= 4'd0;
            end else if (start_req) begin
                clearing_q <= 1'b0;
                ram_a      <= addr;
                if (we) begin
                    ram_di <= wdata;
                end
            end else if ((state_q == StWHold) && clearing_q) begin
                // Counter wraps to 0 after 15; ram_a keeps 15 on the way back to IDLE.
                clr_cnt_q <= clr_cnt_q + 4'd1;
                if (clr_cnt_q == 4'd15) begin
                    clearing_q <= 1'b0;
                end else begin
                    ram_a <= clr_cnt_q + 4'd1;
                end
            end
            // RAM drives complemented data; store it in true polarity.
            if ((state_q == StRSetup) && (wait_q == 4'd0)) begin
                rdata <= ~ram_do;
            end
        end
    end

endmodule

// File: tb/tb_ram16x4_master.sv
// Bench for ram16x4_master: two instances (default timing and WR_PULSE=3/RD_WAIT=2),
// each wired to its own behavioural SN74189, checked against a word-level memory model.
module tb_ram16x4_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            clr;
    logic [1:0]      req, we, clr_req;
    logic [1:0][3:0] addr, wdata;
    logic [1:0]      busy, done, s_bar, w_bar;
    logic [1:0][3:0] rdata, ram_a, ram_di;
    wire  [1:0][3:0] ram_do;

    int checks = 0;
    int errors = 0;

    ram16x4_master u_dut0 (
        .CLK(clk), .CLR(clr), .req(req[0]), .we(we[0]), .addr(addr[0]),
        .wdata(wdata[0]), .clr_req(clr_req[0]), .busy(busy[0]), .done(done[0]),
        .rdata(rdata[0]), .ram_a(ram_a[0]), .ram_di(ram_di[0]), .ram_do(ram_do[0]),
        .ram_s_bar(s_bar[0]), .ram_w_bar(w_bar[0])
    );

    ram16x4_master #(.WR_PULSE(3), .RD_WAIT(2)) u_dut1 (
        .CLK(clk), .CLR(clr), .req(req[1]), .we(we[1]), .addr(addr[1]),
        .wdata(wdata[1]), .clr_req(clr_req[1]), .busy(busy[1]), .done(done[1]),
        .rdata(rdata[1]), .ram_a(ram_a[1]), .ram_di(ram_di[1]), .ram_do(ram_do[1]),
        .ram_s_bar(s_bar[1]), .ram_w_bar(w_bar[1])
    );

    // SN74189 model: stores as-is, reads back complemented, floats otherwise.
    logic [3:0] chip [2][16];
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!s_bar[d] && !w_bar[d]) chip[d][ram_a[d]] <= ram_di[d];
        end
    end
    assign ram_do[0] = (!s_bar[0] && w_bar[0]) ? ~chip[0][ram_a[0]] : 4'bz;
    assign ram_do[1] = (!s_bar[1] && w_bar[1]) ? ~chip[1][ram_a[1]] : 4'bz;

    // Reference model
    logic [3:0] ref_mem [2][16];
    logic [3:0] last_rd [2];
    int         ops [2]      = '{0, 0};
    int         done_cnt [2] = '{0, 0};

    function automatic int wp(input int d);
        return (d != 0) ? 3 : 1;
    endfunction

    function automatic int rw(input int d);
        return (d != 0) ? 2 : 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Done pulse counting and address/data stability while the write strobe is low
    logic [1:0]      prev_wlow = '0;
    logic [1:0][3:0] prev_a, prev_di;
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (done[d]) done_cnt[d] <= done_cnt[d] + 1;
            if (!w_bar[d] && prev_wlow[d]) begin
                check("ram_a_stable", ram_a[d], prev_a[d]);
                check("ram_di_stable", ram_di[d], prev_di[d]);
            end
            prev_wlow[d] <= !w_bar[d];
            prev_a[d]    <= ram_a[d];
            prev_di[d]   <= ram_di[d];
        end
    end

    // Issue one transaction at this negedge; returns at the negedge of the done cycle
    // with req still high, so a following call is back-to-back.
    task automatic do_op(input int d, input bit w, input logic [3:0] a, input logic [3:0] v,
                         input bit poke);
        int         n;
        int         lowc;
        bit         seen;
        logic [3:0] exp_do;
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = v;
        @(posedge clk);
        ops[d]++;
        if (w) ref_mem[d][a] = v;
        exp_do = ~ref_mem[d][a];
        n = 0; lowc = 0; seen = 1'b0;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("busy_after_accept", busy[d], 1);
                if (poke) begin
                    we[d] = 1'b1; addr[d] = a + 4'd1; wdata[d] = ~v;
                end
            end
            if (n == 2 && poke) req[d] = 1'b0;
            if (w ? !w_bar[d] : !s_bar[d]) lowc++;
            if (!w && n == rw(d)) check("ram_do", ram_do[d], exp_do);
            if (done[d]) seen = 1'b1;
        end
        check(w ? "wr_latency" : "rd_latency", n, w ? 3 + wp(d) : 2 + rw(d));
        check(w ? "w_bar_low_cycles" : "s_bar_low_cycles", lowc, w ? wp(d) : rw(d));
        check("busy_at_done", busy[d], 0);
        if (!w) begin
            check("rdata", rdata[d], ref_mem[d][a]);
            last_rd[d] = ref_mem[d][a];
        end
    endtask

    task automatic do_clear(input int d, input bit with_req);
        int n;
        int busyc;
        bit seen;
        clr_req[d] = 1'b1;
        if (with_req) begin
            req[d] = 1'b1; we[d] = 1'b1; addr[d] = 4'd7; wdata[d] = 4'd9;
        end
        @(posedge clk);
        ops[d]++;
        for (int k = 0; k < 16; k++) ref_mem[d][k] = 4'd0;
        n = 0; busyc = 0; seen = 1'b0;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                clr_req[d] = 1'b0; req[d] = 1'b0;
            end
            if (busy[d]) busyc++;
            if (done[d]) seen = 1'b1;
        end
        check("clr_latency", n, 1 + 16 * (wp(d) + 2));
        check("clr_busy_cycles", busyc, 16 * (wp(d) + 2));
        check("clr_keeps_rdata", rdata[d], last_rd[d]);
    endtask

    task automatic check_dones(input int d);
        #1;
        check("done_count", done_cnt[d], ops[d]);
    endtask

    initial begin
        clr = 1'b1; req = '0; we = '0; clr_req = '0; addr = '0; wdata = '0;
        last_rd = '{4'd0, 4'd0};
        repeat (3) @(negedge clk);
        check("rst_s_bar", s_bar, 2'b11);
        check("rst_w_bar", w_bar, 2'b11);
        check("rst_busy", busy, 2'b00);
        check("rst_done", done, 2'b00);
        check("rst_rdata", rdata, 8'h00);
        check("rst_ram_a", ram_a, 8'h00);
        check("rst_ram_di", ram_di, 8'h00);
        clr = 1'b0;

        // Write then read back through the RAM model
        do_op(0, 1'b1, 4'd3, 4'hA, 1'b0);
        do_op(0, 1'b0, 4'd3, 4'h0, 1'b0);
        req[0] = 1'b0;
        check_dones(0);

        // Reset in the middle of a write pulse
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 4'd6; wdata[0] = 4'hC;
        @(negedge clk);
        req[0] = 1'b0;
        @(negedge clk);
        check("w_bar_low_before_reset", w_bar[0], 0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("abort_w_bar", w_bar[0], 1);
        check("abort_s_bar", s_bar[0], 1);
        check("abort_busy", busy[0], 0);
        check("abort_done", done[0], 0);
        check("abort_rdata", rdata[0], 0);
        check("abort_ram_a", ram_a[0], 0);
        last_rd[0] = 4'd0;
        check_dones(0);

        // Fill back-to-back, then random readback (one op pokes req while busy)
        for (int k = 0; k < 16; k++) do_op(0, 1'b1, 4'(k), 4'(k + 5), 1'b0);
        for (int i = 0; i < 20; i++) do_op(0, 1'b0, 4'($urandom_range(15)), 4'h0, i == 7);
        req[0] = 1'b0;
        check_dones(0);

        // Fill with F, clear with req also high: clear wins, req dropped
        for (int k = 0; k < 16; k++) do_op(0, 1'b1, 4'(k), 4'hF, 1'b0);
        req[0] = 1'b0;
        @(negedge clk);
        do_clear(0, 1'b1);
        for (int k = 0; k < 16; k++) do_op(0, 1'b0, 4'(k), 4'h0, 1'b0);
        req[0] = 1'b0;
        check_dones(0);

        // Non-default timing instance
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            do_op(1, 1'b1, 4'(i * 5 + 1), 4'($urandom_range(15)), 1'b0);
        end
        for (int i = 0; i < 4; i++) do_op(1, 1'b0, 4'(i * 5 + 1), 4'h0, 1'b0);
        do_clear(1, 1'b0);
        @(negedge clk);
        do_op(1, 1'b0, 4'd6, 4'h0, 1'b0);
        do_op(1, 1'b0, 4'd11, 4'h0, 1'b0);
        req[1] = 1'b0;
        check_dones(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
